// File: rtl/brick_pkg.sv
// Shared types, layout constants and slot geometry helpers for the brick/paddle game controller.
package brick_pkg;

    localparam int unsigned NUM_BRICKS  = 9;
    localparam int unsigned NUM_SLOTS   = 10;
    localparam int unsigned PADDLE_SLOT = 9;
    localparam int unsigned CW          = 10;
    localparam int unsigned IDX_W       = 4;
    localparam int unsigned SCORE_W     = 8;

    localparam logic [CW-1:0] BRICK_X0 = 10'd160;
    localparam logic [CW-1:0] BRICK_Y0 = 10'd60;
    localparam logic [CW-1:0] PITCH_X  = 10'd120;
    localparam logic [CW-1:0] PITCH_Y  = 10'd40;
    localparam logic [CW-1:0] PADDLE_Y = 10'd440;

    typedef enum logic [2:0] {IDLE, SCAN, RESOLVE, PADDLE, DONE} brick_state_t;

    typedef struct packed {
        logic [CW-1:0] x;
        logic [CW-1:0] y;
    } slot_geom_t;

    // Bricks form a 3x3 grid; slot 9 is the paddle, which only moves in x.
    function automatic logic [CW-1:0] slot_x(input logic [IDX_W-1:0] s, input logic [CW-1:0] paddle_x);
        logic [CW-1:0] col;
        col = CW'(s % IDX_W'(3));
        if (s == IDX_W'(PADDLE_SLOT)) return paddle_x;
        return BRICK_X0 + col * PITCH_X;
    endfunction

    function automatic logic [CW-1:0] slot_y(input logic [IDX_W-1:0] s);
        logic [CW-1:0] row;
        row = CW'(s / IDX_W'(3));
        if (s == IDX_W'(PADDLE_SLOT)) return PADDLE_Y;
        return BRICK_Y0 + row * PITCH_Y;
    endfunction

endpackage

// File: rtl/brick_controller_if.sv
// Frame-control, ball geometry and brick-state signals between game logic and the brick controller.
interface brick_controller_if;
    import brick_pkg::*;

    logic                       frame_tick;
    logic                       new_level;
    logic [CW-1:0]              BallX;
    logic [CW-1:0]              BallY;
    logic [CW-1:0]              Ball_size;
    logic [CW-1:0]              paddle_x;
    logic [CW-1:0]              brick_width;
    logic [CW-1:0]              brick_height;
    logic [NUM_BRICKS-1:0]      brick_exists;
    logic [NUM_SLOTS*CW-1:0]    brick_x_vals;
    logic [NUM_SLOTS*CW-1:0]    brick_y_vals;
    logic                       bounce_x;
    logic                       bounce_y;
    logic [SCORE_W-1:0]         score;
    logic                       level_clear;
    logic                       busy;
    logic                       overrun;

    modport master (
        output frame_tick, new_level, BallX, BallY, Ball_size, paddle_x, brick_width, brick_height,
        input  brick_exists, brick_x_vals, brick_y_vals, bounce_x, bounce_y, score, level_clear, busy, overrun
    );

    modport slave (
        input  frame_tick, new_level, BallX, BallY, Ball_size, paddle_x, brick_width, brick_height,
        output brick_exists, brick_x_vals, brick_y_vals, bounce_x, bounce_y, score, level_clear, busy, overrun
    );

endinterface

// File: rtl/brick_hit_test.sv
// Combinational ball-versus-rectangle overlap test; the ball is a square of half-width ball_size_i.
module brick_hit_test
    import brick_pkg::*;
(
    input  slot_geom_t     slot_i,
    input  logic [CW-1:0]  ball_x_i,
    input  logic [CW-1:0]  ball_y_i,
    input  logic [CW-1:0]  ball_size_i,
    input  logic [CW-1:0]  width_i,
    input  logic [CW-1:0]  height_i,
    output logic           hit_c_o,
    output logic           x_inside_c_o
);

    localparam int unsigned SW = CW + 1;

    logic [SW-1:0] bx, by, sz, sx, sy, w, h;

    assign bx = SW'(ball_x_i);
    assign by = SW'(ball_y_i);
    assign sz = SW'(ball_size_i);
    assign sx = SW'(slot_i.x);
    assign sy = SW'(slot_i.y);
    assign w  = SW'(width_i);
    assign h  = SW'(height_i);

    assign hit_c_o = (bx + sz >= sx) && (bx < sx + w + sz) &&
                     (by + sz >= sy) && (by < sy + h + sz);

    // Centre inside the column span means a top/bottom hit, otherwise a side hit.
    assign x_inside_c_o = (bx >= sx) && (bx < sx + w);

endmodule

// File: rtl/brick_controller.sv
// Per-frame scan of nine bricks and the paddle against the ball; clears the first hit brick,
// keeps score and issues single-cycle bounce pulses.
module brick_controller
    import brick_pkg::*;
(
    input  logic               Clk,
    input  logic               Reset_n,
    brick_controller_if.slave  bus
);

    brick_state_t           state_q, state_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [IDX_W-1:0]       hit_idx_q, hit_idx_d;
    logic [NUM_BRICKS-1:0]  exists_q, exists_d;
    logic [SCORE_W-1:0]     score_q, score_d;
    logic                   bounce_x_q, bounce_x_d;
    logic                   bounce_y_q, bounce_y_d;
    logic                   busy_q, busy_d;
    logic                   overrun_q, overrun_d;
    logic                   level_clear_q, level_clear_d;
    logic                   pend_q, pend_d;

    logic [IDX_W-1:0]       sel_c;
    slot_geom_t             geom_c;
    logic                   hit_c;
    logic                   x_inside_c;
    logic [NUM_SLOTS*CW-1:0] x_vals_c, y_vals_c;

    // One hit tester serves the scan, the resolve direction check and the paddle check.
    always_comb begin
        sel_c = idx_q;
        if (state_q == RESOLVE)     sel_c = hit_idx_q;
        else if (state_q == PADDLE) sel_c = IDX_W'(PADDLE_SLOT);
        geom_c.x = slot_x(sel_c, bus.paddle_x);
        geom_c.y = slot_y(sel_c);
    end

    brick_hit_test u_hit (
        .slot_i       (geom_c),
        .ball_x_i     (bus.BallX),
        .ball_y_i     (bus.BallY),
        .ball_size_i  (bus.Ball_size),
        .width_i      (bus.brick_width),
        .height_i     (bus.brick_height),
        .hit_c_o      (hit_c),
        .x_inside_c_o (x_inside_c)
    );

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        hit_idx_d   = hit_idx_q;
        exists_d    = exists_q;
        score_d     = score_q;
        bounce_x_d  = 1'b0;
        bounce_y_d  = 1'b0;
        overrun_d   = overrun_q;
        pend_d      = pend_q;

        // A late frame_tick wins over a simultaneous overrun clear.
        if (bus.new_level) overrun_d = 1'b0;
        if (bus.frame_tick && state_q != IDLE) overrun_d = 1'b1;
        if (bus.new_level && state_q != IDLE && state_q != DONE) pend_d = 1'b1;

        unique case (state_q)
            IDLE: begin
                if (bus.new_level) begin
                    exists_d = '1;
                end else if (bus.frame_tick) begin
                    idx_d   = '0;
                    state_d = SCAN;
                end
            end
            SCAN: begin
                if (exists_q[idx_q] && hit_c) begin
                    hit_idx_d = idx_q;
                    state_d   = RESOLVE;
                end else if (idx_q == IDX_W'(NUM_BRICKS - 1)) begin
                    state_d = PADDLE;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            RESOLVE: begin
                exists_d[hit_idx_q] = 1'b0;
                if (score_q != '1) score_d = score_q + SCORE_W'(1);
                if (x_inside_c) bounce_y_d = 1'b1;
                else            bounce_x_d = 1'b1;
                state_d = PADDLE;
            end
            PADDLE: begin
                if (hit_c) bounce_y_d = 1'b1;
                state_d = DONE;
            end
            DONE: begin
                if (pend_q || bus.new_level) begin
                    exists_d = '1;
                    pend_d   = 1'b0;
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        busy_d        = (state_d != IDLE);
        level_clear_d = (exists_q == '0);
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q       <= IDLE;
            idx_q         <= '0;
            hit_idx_q     <= '0;
            exists_q      <= '1;
            score_q       <= '0;
            bounce_x_q    <= 1'b0;
            bounce_y_q    <= 1'b0;
            busy_q        <= 1'b0;
            overrun_q     <= 1'b0;
            level_clear_q <= 1'b0;
            pend_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            hit_idx_q     <= hit_idx_d;
            exists_q      <= exists_d;
            score_q       <= score_d;
            bounce_x_q    <= bounce_x_d;
            bounce_y_q    <= bounce_y_d;
            busy_q        <= busy_d;
            overrun_q     <= overrun_d;
            level_clear_q <= level_clear_d;
            pend_q        <= pend_d;
        end
    end

    // Layout buses track paddle_x directly so the display sees paddle motion without delay.
    always_comb begin
        x_vals_c = '0;
        y_vals_c = '0;
        for (int unsigned s = 0; s < NUM_SLOTS; s++) begin
            x_vals_c[s*CW +: CW] = slot_x(IDX_W'(s), bus.paddle_x);
            y_vals_c[s*CW +: CW] = slot_y(IDX_W'(s));
        end
    end

    assign bus.brick_x_vals = x_vals_c;
    assign bus.brick_y_vals = y_vals_c;
    assign bus.brick_exists = exists_q;
    assign bus.score        = score_q;
    assign bus.bounce_x     = bounce_x_q;
    assign bus.bounce_y     = bounce_y_q;
    assign bus.busy         = busy_q;
    assign bus.overrun      = overrun_q;
    assign bus.level_clear  = level_clear_q;

endmodule

// File: tb/tb_brick_controller.sv
// Scoreboard bench for brick_controller: stimulus queues expected bounces and end-of-frame state,
// a monitor measures latencies from busy rising and compares.
module tb_brick_controller;

    logic clk = 1'b0;
    logic rst_n;

    brick_controller_if bus();

    brick_controller dut (
        .Clk     (clk),
        .Reset_n (rst_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        int   lat;
        logic bx;
        logic by;
    } bexp_t;

    typedef struct {
        int         len;
        logic [8:0] ex;
        logic [7:0] sc;
        logic       ov;
        logic       lc;
    } fexp_t;

    bexp_t bq[$];
    fexp_t fq[$];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: all timing is measured from the sample where busy first goes high.
    int         cyc = 0;
    int         t0 = 0;
    logic       busy_prev = 1'b0;
    logic [8:0] ex_prev = 9'h1FF;
    logic [8:0] ex_prev2 = 9'h1FF;

    always @(posedge clk) begin
        bexp_t be;
        fexp_t fe;
        #1;
        cyc++;
        if (!rst_n) begin
            busy_prev = 1'b0;
            ex_prev   = 9'h1FF;
            ex_prev2  = 9'h1FF;
        end else begin
            if (bus.busy && !busy_prev) t0 = cyc;
            if (bus.bounce_x || bus.bounce_y) begin
                if (bq.size() == 0) begin
                    chk("unexpected_bounce", {30'd0, bus.bounce_x, bus.bounce_y}, 32'd0);
                end else begin
                    be = bq.pop_front();
                    chk("bounce_kind", {30'd0, bus.bounce_x, bus.bounce_y}, {30'd0, be.bx, be.by});
                    chk("bounce_latency", cyc - t0, be.lat);
                end
            end
            if (!bus.busy && busy_prev) begin
                if (fq.size() == 0) begin
                    chk("unexpected_frame", fq.size(), 1);
                end else begin
                    fe = fq.pop_front();
                    chk("busy_len", cyc - t0, fe.len);
                    chk("exists", bus.brick_exists, fe.ex);
                    chk("score", bus.score, fe.sc);
                    chk("overrun", bus.overrun, fe.ov);
                    chk("level_clear_end", bus.level_clear, fe.lc);
                end
            end
            if (ex_prev != ex_prev2) chk("level_clear_lag", bus.level_clear, ex_prev == 9'd0);
            ex_prev2  = ex_prev;
            ex_prev   = bus.brick_exists;
            busy_prev = bus.busy;
        end
    end

    task automatic reset_checks(input string tag);
        chk({tag, "_exists"}, bus.brick_exists, 9'h1FF);
        chk({tag, "_score"}, bus.score, 0);
        chk({tag, "_bounce"}, {bus.bounce_x, bus.bounce_y}, 0);
        chk({tag, "_busy"}, bus.busy, 0);
        chk({tag, "_overrun"}, bus.overrun, 0);
        chk({tag, "_level_clear"}, bus.level_clear, 0);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (bus.busy && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (n >= 40) chk("busy_timeout", bus.busy, 0);
        repeat (2) @(negedge clk);
    endtask

    // lat < 0 means no bounce expected this frame.
    task automatic run_frame(input logic [9:0] x, input logic [9:0] y, input logic [9:0] sz,
                             input int lat, input logic ebx, input logic eby,
                             input int len, input logic [8:0] ex, input logic [7:0] sc,
                             input logic ov, input logic lc);
        @(negedge clk);
        bus.BallX      = x;
        bus.BallY      = y;
        bus.Ball_size  = sz;
        bus.frame_tick = 1'b1;
        if (lat >= 0) bq.push_back('{lat, ebx, eby});
        fq.push_back('{len, ex, sc, ov, lc});
        @(negedge clk);
        bus.frame_tick = 1'b0;
        wait_idle();
    endtask

    initial begin
        logic [8:0] ex_exp;
        rst_n            = 1'b0;
        bus.frame_tick   = 1'b0;
        bus.new_level    = 1'b0;
        bus.BallX        = 10'd10;
        bus.BallY        = 10'd10;
        bus.Ball_size    = 10'd4;
        bus.paddle_x     = 10'd300;
        bus.brick_width  = 10'd80;
        bus.brick_height = 10'd20;
        repeat (3) @(negedge clk);
        reset_checks("rst");
        rst_n = 1'b1;
        @(negedge clk);
        reset_checks("post_rst");

        // Ball far away, then single brick hits, double overlap, paddle, side hit, worst case.
        run_frame(10'd10,  10'd10,  10'd4,  -1, 0, 0, 11, 9'h1FF, 8'd0, 0, 0);
        run_frame(10'd300, 10'd110, 10'd4,   6, 0, 1,  8, 9'h1EF, 8'd1, 0, 0);
        run_frame(10'd260, 10'd70,  10'd24,  2, 1, 0,  4, 9'h1EE, 8'd2, 0, 0);
        run_frame(10'd260, 10'd70,  10'd24,  3, 1, 0,  5, 9'h1EC, 8'd3, 0, 0);
        run_frame(10'd297, 10'd445, 10'd4,  10, 0, 1, 11, 9'h1EC, 8'd3, 0, 0);
        run_frame(10'd397, 10'd110, 10'd4,   7, 1, 0,  9, 9'h1CC, 8'd4, 0, 0);
        run_frame(10'd440, 10'd150, 10'd4,  10, 0, 1, 12, 9'h0CC, 8'd5, 0, 0);

        // Reset mid-scan with brick 7 about to be hit: the pending bounce must vanish.
        @(negedge clk);
        bus.BallX = 10'd320;
        bus.BallY = 10'd150;
        bus.frame_tick = 1'b1;
        @(negedge clk);
        bus.frame_tick = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        reset_checks("mid_rst");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (14) @(negedge clk);
        reset_checks("after_mid_rst");

        run_frame(10'd320, 10'd110, 10'd4, 6, 0, 1, 8, 9'h1EF, 8'd1, 0, 0);

        // new_level and a late frame_tick during a scan: restore deferred to DONE, overrun sticks.
        @(negedge clk);
        bus.BallX = 10'd10;
        bus.BallY = 10'd10;
        bus.frame_tick = 1'b1;
        fq.push_back('{11, 9'h1FF, 8'd1, 1'b1, 1'b0});
        @(negedge clk);
        bus.frame_tick = 1'b0;
        @(negedge clk);
        bus.new_level = 1'b1;
        @(negedge clk);
        bus.new_level = 1'b0;
        bus.frame_tick = 1'b1;
        @(negedge clk);
        bus.frame_tick = 1'b0;
        chk("pending_keeps_old", bus.brick_exists, 9'h1EF);
        wait_idle();

        // Clear every brick in turn, hitting each at its centre.
        for (int i = 0; i < 9; i++) begin
            ex_exp = 9'h1FF;
            ex_exp = ex_exp << (i + 1);
            run_frame(10'(200 + (i % 3) * 120), 10'(70 + (i / 3) * 40), 10'd4,
                      i + 2, 0, 1, i + 4, ex_exp, 8'(2 + i), 1'b1, i == 8);
        end

        // new_level and frame_tick together while idle: restore only, no scan, overrun cleared.
        @(negedge clk);
        bus.new_level  = 1'b1;
        bus.frame_tick = 1'b1;
        @(negedge clk);
        bus.new_level  = 1'b0;
        bus.frame_tick = 1'b0;
        chk("idle_restore_exists", bus.brick_exists, 9'h1FF);
        chk("idle_restore_busy", bus.busy, 0);
        chk("idle_restore_overrun", bus.overrun, 0);
        chk("idle_restore_score", bus.score, 10);
        @(negedge clk);
        chk("idle_restore_level_clear", bus.level_clear, 0);
        repeat (14) @(negedge clk);

        chk("bounce_queue_drained", bq.size(), 0);
        chk("frame_queue_drained", fq.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
